// File: rtl/wm_water_level_ctrl_if.sv
// ---------------------------------------------------------------------------
// wm_water_level_ctrl_if
//   Bundle between the main cycle FSM / plant sensors and the water-level
//   sequencer.
//   master : cycle FSM side. It drives the command, abort, pause, door and level
//            signals and observes the ready, valve and status signals.
//   slave  : the sequencer, wm_water_level_ctrl.
//   Signals: cmd_valid/cmd_ready/cmd_op/cmd_target (command handshake),
//            abort, pause, door_closed, water_level (control and sensor inputs),
//            water_valve, drain_valve, busy, done, err_code (outputs).
// ---------------------------------------------------------------------------
interface wm_water_level_ctrl_if #(
   parameter int LEVEL_W = 8
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [LEVEL_W-1:0] cmd_target;
   logic               abort;
   logic               pause;
   logic               door_closed;
   logic [LEVEL_W-1:0] water_level;
   logic               water_valve;
   logic               drain_valve;
   logic               busy;
   logic               done;
   logic [1:0]         err_code;

   modport master (
      output cmd_valid, cmd_op, cmd_target, abort, pause, door_closed, water_level,
      input  cmd_ready, water_valve, drain_valve, busy, done, err_code
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_target, abort, pause, door_closed, water_level,
      output cmd_ready, water_valve, drain_valve, busy, done, err_code
   );
endinterface

// File: rtl/wm_water_level_ctrl.sv
// ---------------------------------------------------------------------------
// wm_water_level_ctrl
//   Water fill/drain sequencer. The block accepts FILL/DRAIN commands and
//   drives the inlet and drain valves until water_level reaches the target.
//   It then closes both valves for SETTLE_CYC cycles, re-checks the level and
//   pulses done. It also handles the door interlock, pause/hold, the
//   per-command active-cycle timeout and abort.
//   Ports:
//     clk  : system clock
//     rst  : synchronous, active-high reset
//     wif  : wm_water_level_ctrl_if.slave. It carries the command handshake,
//            abort, pause, door_closed and water_level inputs, and the
//            registered outputs water_valve, drain_valve, busy, done,
//            cmd_ready and err_code.
//   Build option:
//     WM_LEVEL_FILTER_EN : threshold and re-check decisions need the
//                          condition on two consecutive level samples.
//                          This rejects single-sample sensor glitches.
// ---------------------------------------------------------------------------
module wm_water_level_ctrl #(
   parameter int LEVEL_W     = 8,
   parameter int TIMEOUT_CYC = 1000,
   parameter int SETTLE_CYC  = 4,
   parameter int HYST        = 2
) (
   input logic                  clk,
   input logic                  rst,
   wm_water_level_ctrl_if.slave wif
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int HW = LEVEL_W + 1;

   localparam logic [1:0] OP_FILL  = 2'b01;
   localparam logic [1:0] OP_DRAIN = 2'b10;
   localparam logic [1:0] ERR_TMO  = 2'b01;
   localparam logic [1:0] ERR_DOOR = 2'b10;
   localparam logic [1:0] ERR_OP   = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_DRAIN, S_SETTLE, S_HOLD, S_FAULT} state_t;

   state_t             state_q, state_n;
   logic               fill_q, fill_n;       // saved op: 1 = FILL, 0 = DRAIN
   logic [LEVEL_W-1:0] tgt_q, tgt_n;
   logic [TW-1:0]      timer_q, timer_n;
   logic [SW-1:0]      scnt_q, scnt_n;
   logic [1:0]         err_q, err_n;
   logic               done_n;

   // The command has not been latched yet in IDLE, so the boundary checks
   // there look at the live cmd_target.
   logic [LEVEL_W-1:0] cmp_tgt;
   logic               fill_hit, drain_hit, refill_ok, tmo, act_hit;

   assign cmp_tgt = (state_q == S_IDLE) ? wif.cmd_target : tgt_q;
   assign tmo     = (timer_q >= TW'(TIMEOUT_CYC - 1));

   function automatic logic ge_c(input logic [LEVEL_W-1:0] l, input logic [LEVEL_W-1:0] t);
      return l >= t;
   endfunction

   function automatic logic le_c(input logic [LEVEL_W-1:0] l, input logic [LEVEL_W-1:0] t);
      return l <= t;
   endfunction

   // The sum is one bit wider than the level, so a full tank plus HYST
   // cannot wrap around.
   function automatic logic refill_c(input logic [LEVEL_W-1:0] l, input logic [LEVEL_W-1:0] t);
      return ({1'b0, l} + HW'(HYST)) >= {1'b0, t};
   endfunction

`ifdef WM_LEVEL_FILTER_EN
   logic [LEVEL_W-1:0] level_q;

   always_ff @(posedge clk) begin
      if (rst) level_q <= '0;
      else     level_q <= wif.water_level;
   end

   assign fill_hit  = ge_c(wif.water_level, cmp_tgt)     && ge_c(level_q, cmp_tgt);
   assign drain_hit = le_c(wif.water_level, cmp_tgt)     && le_c(level_q, cmp_tgt);
   assign refill_ok = refill_c(wif.water_level, cmp_tgt) && refill_c(level_q, cmp_tgt);
`else
   assign fill_hit  = ge_c(wif.water_level, cmp_tgt);
   assign drain_hit = le_c(wif.water_level, cmp_tgt);
   assign refill_ok = refill_c(wif.water_level, cmp_tgt);
`endif

   always_comb begin
      state_n = state_q;
      fill_n  = fill_q;
      tgt_n   = tgt_q;
      timer_n = timer_q;
      scnt_n  = scnt_q;
      err_n   = err_q;
      done_n  = 1'b0;
      act_hit = (state_q == S_FILL) ? fill_hit : drain_hit;

      if (wif.abort) begin
         state_n = S_IDLE;
         err_n   = 2'b00;
         scnt_n  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               // cmd_ready is high in every IDLE cycle, so cmd_valid alone
               // accepts the command.
               if (wif.cmd_valid) begin
                  tgt_n   = wif.cmd_target;
                  timer_n = '0;
                  scnt_n  = '0;
                  fill_n  = (wif.cmd_op == OP_FILL);
                  if (wif.cmd_op == OP_FILL) begin
                     if (!wif.door_closed) begin
                        state_n = S_FAULT;
                        err_n   = ERR_DOOR;
                     end else begin
                        state_n = fill_hit ? S_SETTLE : S_FILL;
                     end
                  end else if (wif.cmd_op == OP_DRAIN) begin
                     state_n = drain_hit ? S_SETTLE : S_DRAIN;
                  end else begin
                     state_n = S_FAULT;
                     err_n   = ERR_OP;
                  end
               end
            end
            S_FILL, S_DRAIN: begin
               // The timer saturates at TIMEOUT_CYC. If the threshold wins in
               // the timeout cycle, a later refill still faults at once.
               timer_n = tmo ? TW'(TIMEOUT_CYC) : timer_q + 1'b1;
               if (state_q == S_FILL && !wif.door_closed) begin
                  state_n = S_FAULT;
                  err_n   = ERR_DOOR;
               end else if (tmo && !act_hit) begin
                  state_n = S_FAULT;
                  err_n   = ERR_TMO;
               end else if (wif.pause) begin
                  state_n = S_HOLD;
               end else if (act_hit) begin
                  state_n = S_SETTLE;
                  scnt_n  = '0;
               end
            end
            S_HOLD: begin
               if (!wif.pause) state_n = fill_q ? S_FILL : S_DRAIN;
            end
            S_SETTLE: begin
               if (scnt_q == SW'(SETTLE_CYC - 1)) begin
                  scnt_n = '0;
                  if (fill_q ? refill_ok : drain_hit) begin
                     state_n = S_IDLE;
                     done_n  = 1'b1;
                  end else begin
                     state_n = fill_q ? S_FILL : S_DRAIN;
                  end
               end else begin
                  scnt_n = scnt_q + 1'b1;
               end
            end
            S_FAULT: state_n = S_FAULT;
            default: state_n = S_IDLE;
         endcase
      end
   end

   // The outputs are decoded from the next state and registered. Only one
   // state opens each valve, so the two valves can never be open together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         fill_q          <= 1'b0;
         tgt_q           <= '0;
         timer_q         <= '0;
         scnt_q          <= '0;
         err_q           <= 2'b00;
         wif.water_valve <= 1'b0;
         wif.drain_valve <= 1'b0;
         wif.busy        <= 1'b0;
         wif.done        <= 1'b0;
         wif.cmd_ready   <= 1'b1;
      end else begin
         state_q         <= state_n;
         fill_q          <= fill_n;
         tgt_q           <= tgt_n;
         timer_q         <= timer_n;
         scnt_q          <= scnt_n;
         err_q           <= err_n;
         wif.water_valve <= (state_n == S_FILL);
         wif.drain_valve <= (state_n == S_DRAIN);
         wif.busy        <= (state_n != S_IDLE);
         wif.done        <= done_n;
         wif.cmd_ready   <= (state_n == S_IDLE);
      end
   end

   assign wif.err_code = err_q;
endmodule

// File: tb/tb_wm_water_level_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wm_water_level_ctrl
//   Self-checking bench for wm_water_level_ctrl with the default parameters
//   (SETTLE 4, TIMEOUT 1000, HYST 2). A simple tank plant moves water_level
//   by one unit for each cycle that a valve is open.
// ---------------------------------------------------------------------------
module tb_wm_water_level_ctrl;
   localparam int SETTLE = 4;
   localparam int TMO    = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   bit   plant_en  = 1'b0;
   bit   both_seen = 1'b0;

   wm_water_level_ctrl_if #(.LEVEL_W(8)) wif ();

   wm_water_level_ctrl #(
      .LEVEL_W(8), .TIMEOUT_CYC(TMO), .SETTLE_CYC(SETTLE), .HYST(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wif(wif)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (wif.water_valve && wif.drain_valve) both_seen = 1'b1;

   typedef struct {
      logic       v;   logic [1:0] op; logic [7:0] tgt;
      logic       ab;  logic       pz; logic       door; logic [7:0] lvl;
      logic       wv;  logic       dv; logic       busy; logic       done;
      logic       rdy; logic [1:0] err;
   } vec_t;

   typedef struct {
      int cyc; int won; int don; int hold_open;
      bit got; bit w0; bit d0; bit rdy;
   } res_t;

   localparam int NV = 23;
   vec_t tbl [NV];

   task automatic tick();
      @(posedge clk); #1;
      if (plant_en) begin
         if (wif.water_valve)      wif.water_level = wif.water_level + 8'd1;
         else if (wif.drain_valve) wif.water_level = wif.water_level - 8'd1;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic idle_in();
      wif.cmd_valid = 1'b0; wif.abort = 1'b0; wif.pause = 1'b0; wif.door_closed = 1'b1;
   endtask

   // Issue one command and run until done or until the cycle bound expires.
   // Index k counts edges from the acceptance edge. pause is high for
   // k in [pw, pw+pl).
   task automatic run_cmd(input logic [1:0] op, input int tgt, input int pw, input int pl,
                          input int bound, output res_t r);
      r = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < bound && !r.got; k++) begin
         wif.cmd_valid  = (k == 0);
         wif.cmd_op     = op;
         wif.cmd_target = tgt[7:0];
         wif.pause      = (k >= pw && k < pw + pl);
         tick();
         r.cyc = k + 1;
         if (k == 0) begin r.w0 = wif.water_valve; r.d0 = wif.drain_valve; end
         if (wif.water_valve) r.won++;
         if (wif.drain_valve) r.don++;
         if (wif.pause && (wif.water_valve || wif.drain_valve)) r.hold_open++;
         if (wif.done) begin r.got = 1'b1; r.rdy = wif.cmd_ready; end
      end
      wif.cmd_valid = 1'b0;
      wif.pause     = 1'b0;
   endtask

   // Transaction-level reference. The valve stays open for |target-level|
   // cycles. A pause window adds its length. The settle period adds SETTLE.
   // The acceptance edge is the +1.
   function automatic void model(input bit fill, input int l0, input int t, input int pl,
                                 output int n, output int cyc, output int lvl_end);
      if (fill) n = (l0 >= t) ? 0 : t - l0;
      else      n = (l0 <= t) ? 0 : l0 - t;
      if (fill) lvl_end = (l0 >= t) ? l0 : t;
      else      lvl_end = (l0 <= t) ? l0 : t;
      cyc = n + pl + SETTLE + 1;
   endfunction

   initial begin
      res_t r;
      int   won;
      int   bad;

      // v op tgt ab pz door lvl | wv dv busy done rdy err
      tbl[0]  = '{1'b0, 2'b00, 8'd0,  1'b0, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
      tbl[1]  = '{1'b1, 2'b11, 8'd5,  1'b0, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11};
      tbl[2]  = '{1'b0, 2'b00, 8'd0,  1'b0, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11};
      tbl[3]  = '{1'b0, 2'b00, 8'd0,  1'b1, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
      tbl[4]  = '{1'b1, 2'b10, 8'd10, 1'b0, 1'b0, 1'b1, 8'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      tbl[5]  = '{1'b0, 2'b00, 8'd0,  1'b0, 1'b1, 1'b1, 8'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      tbl[6]  = '{1'b0, 2'b00, 8'd0,  1'b0, 1'b0, 1'b1, 8'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      tbl[7]  = '{1'b0, 2'b00, 8'd0,  1'b0, 1'b0, 1'b1, 8'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      tbl[8]  = '{1'b0, 2'b00, 8'd0,  1'b0, 1'b0, 1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
      tbl[9]  = '{1'b0, 2'b00, 8'd0,  1'b0, 1'b0, 1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
      tbl[10] = '{1'b1, 2'b01, 8'd30, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10};
      tbl[11] = '{1'b1, 2'b01, 8'd30, 1'b1, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
      tbl[12] = '{1'b1, 2'b01, 8'd20, 1'b0, 1'b0, 1'b1, 8'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      tbl[13] = '{1'b0, 2'b00, 8'd0,  1'b0, 1'b1, 1'b1, 8'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      tbl[14] = '{1'b0, 2'b00, 8'd0,  1'b0, 1'b0, 1'b1, 8'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      tbl[15] = '{1'b0, 2'b00, 8'd0,  1'b0, 1'b1, 1'b1, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      tbl[16] = '{1'b0, 2'b00, 8'd0,  1'b0, 1'b0, 1'b1, 8'd20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      tbl[17] = '{1'b0, 2'b00, 8'd0,  1'b1, 1'b0, 1'b1, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
      tbl[18] = '{1'b0, 2'b00, 8'd0,  1'b0, 1'b0, 1'b1, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
      tbl[19] = '{1'b1, 2'b10, 8'd0,  1'b0, 1'b0, 1'b1, 8'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
      tbl[20] = '{1'b0, 2'b00, 8'd0,  1'b0, 1'b0, 1'b1, 8'd1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
      tbl[21] = '{1'b0, 2'b00, 8'd0,  1'b0, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      tbl[22] = '{1'b0, 2'b00, 8'd0,  1'b1, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};

      idle_in();
      wif.cmd_op = 2'b00; wif.cmd_target = 8'd0; wif.water_level = 8'd0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      chk("rst.water_valve", int'(wif.water_valve), 0);
      chk("rst.drain_valve", int'(wif.drain_valve), 0);
      chk("rst.busy",        int'(wif.busy),        0);
      chk("rst.done",        int'(wif.done),        0);
      chk("rst.cmd_ready",   int'(wif.cmd_ready),   1);
      chk("rst.err_code",    int'(wif.err_code),    0);

      // Single-cycle vectors: one edge per row, outputs checked after the edge.
      for (int i = 0; i < NV; i++) begin
         wif.cmd_valid = tbl[i].v;  wif.cmd_op = tbl[i].op; wif.cmd_target = tbl[i].tgt;
         wif.abort = tbl[i].ab;     wif.pause = tbl[i].pz;  wif.door_closed = tbl[i].door;
         wif.water_level = tbl[i].lvl;
         tick();
         chk($sformatf("vec%0d.water_valve", i), int'(wif.water_valve), int'(tbl[i].wv));
         chk($sformatf("vec%0d.drain_valve", i), int'(wif.drain_valve), int'(tbl[i].dv));
         chk($sformatf("vec%0d.busy", i),        int'(wif.busy),        int'(tbl[i].busy));
         chk($sformatf("vec%0d.done", i),        int'(wif.done),        int'(tbl[i].done));
         chk($sformatf("vec%0d.cmd_ready", i),   int'(wif.cmd_ready),   int'(tbl[i].rdy));
         chk($sformatf("vec%0d.err_code", i),    int'(wif.err_code),    int'(tbl[i].err));
      end
      idle_in();

      // FILL to 40 from 0 while the level ramps.
      wif.water_level = 8'd0; plant_en = 1'b1;
      run_cmd(2'b01, 40, 0, 0, 100, r);
      chk("fill40.valve_next_cycle", int'(r.w0), 1);
      chk("fill40.valve_cycles", r.won, 40);
      chk("fill40.done_seen", int'(r.got), 1);
      chk("fill40.done_cycle", r.cyc, 40 + SETTLE + 1);
      chk("fill40.ready_at_done", int'(r.rdy), 1);
      chk("fill40.level", int'(wif.water_level), 40);
      chk("fill40.err", int'(wif.err_code), 0);
      tick();
      chk("fill40.done_one_cycle", int'(wif.done), 0);

      // DRAIN to 0 from 30 with a 10-cycle pause in the middle.
      wif.water_level = 8'd30;
      run_cmd(2'b10, 0, 10, 10, 100, r);
      chk("drain0.valve_next_cycle", int'(r.d0), 1);
      chk("drain0.valve_cycles", r.don, 30);
      chk("drain0.valve_in_hold", r.hold_open, 0);
      chk("drain0.done_cycle", r.cyc, 30 + 10 + SETTLE + 1);
      chk("drain0.level", int'(wif.water_level), 0);
      tick();
      chk("drain0.done_once", int'(wif.done), 0);

      // Timeout: the level is stuck at 10 while filling to 50.
      plant_en = 1'b0; wif.water_level = 8'd10;
      wif.cmd_valid = 1'b1; wif.cmd_op = 2'b01; wif.cmd_target = 8'd50;
      won = 0;
      for (int k = 0; k < TMO + 100 && wif.err_code == 2'b00; k++) begin
         tick();
         wif.cmd_valid = 1'b0;
         if (wif.water_valve) won++;
      end
      chk("tmo.valve_cycles", won, TMO);
      chk("tmo.err", int'(wif.err_code), 1);
      chk("tmo.water_valve", int'(wif.water_valve), 0);
      chk("tmo.cmd_ready", int'(wif.cmd_ready), 0);
      wif.abort = 1'b1; tick(); wif.abort = 1'b0;
      chk("tmo.abort_err", int'(wif.err_code), 0);
      chk("tmo.abort_ready", int'(wif.cmd_ready), 1);
      chk("tmo.abort_busy", int'(wif.busy), 0);

      // The door opens at level 20 during a FILL to 60.
      plant_en = 1'b1; wif.water_level = 8'd0;
      wif.cmd_valid = 1'b1; wif.cmd_op = 2'b01; wif.cmd_target = 8'd60;
      tick();
      wif.cmd_valid = 1'b0;
      for (int k = 0; k < 100 && wif.water_level < 8'd20; k++) tick();
      wif.door_closed = 1'b0;
      tick();
      chk("door.err", int'(wif.err_code), 2);
      chk("door.water_valve", int'(wif.water_valve), 0);
      wif.door_closed = 1'b1; wif.abort = 1'b1; tick(); wif.abort = 1'b0;
      chk("door.abort_err", int'(wif.err_code), 0);

      // The level sags during settle, which forces a refill.
      wif.water_level = 8'd30;
      wif.cmd_valid = 1'b1; wif.cmd_op = 2'b01; wif.cmd_target = 8'd40;
      tick();
      wif.cmd_valid = 1'b0;
      for (int k = 0; k < 50 && wif.water_valve; k++) tick();
      plant_en = 1'b0; wif.water_level = 8'd36;
      bad = 0;
      repeat (SETTLE - 1) begin
         tick();
         if (wif.water_valve || wif.done) bad++;
      end
      chk("sag.quiet_settle", bad, 0);
      tick();
      chk("sag.refill_valve", int'(wif.water_valve), 1);
      chk("sag.no_done", int'(wif.done), 0);
      plant_en = 1'b1;
      r.got = 1'b0;
      for (int k = 0; k < 50 && !r.got; k++) begin
         tick();
         if (wif.done) r.got = 1'b1;
      end
      chk("sag.done_seen", int'(r.got), 1);
      chk("sag.level", int'(wif.water_level), 40);

      // Random commands checked against the transaction-level model.
      for (int t = 0; t < 24; t++) begin
         bit fill;
         int tgt, l0, pw, pl, n, ecyc, elvl;
         fill = ($urandom_range(0, 1) == 1);
         tgt  = $urandom_range(0, 200);
         l0   = $urandom_range(0, 250);
         n    = fill ? ((l0 >= tgt) ? 0 : tgt - l0) : ((l0 <= tgt) ? 0 : l0 - tgt);
         pw   = 0; pl = 0;
         if (n >= 2 && $urandom_range(0, 1) == 1) begin
            pw = $urandom_range(1, n - 1);
            pl = $urandom_range(1, 8);
         end
         model(fill, l0, tgt, pl, n, ecyc, elvl);
         wif.water_level = l0[7:0];
         run_cmd(fill ? 2'b01 : 2'b10, tgt, pw, pl, ecyc + 20, r);
         chk($sformatf("rnd%0d.done_seen", t), int'(r.got), 1);
         chk($sformatf("rnd%0d.done_cycle", t), r.cyc, ecyc);
         chk($sformatf("rnd%0d.fill_cycles", t), r.won, fill ? n : 0);
         chk($sformatf("rnd%0d.drain_cycles", t), r.don, fill ? 0 : n);
         chk($sformatf("rnd%0d.level", t), int'(wif.water_level), elvl);
         chk($sformatf("rnd%0d.err", t), int'(wif.err_code), 0);
      end

      chk("valves_never_both", int'(both_seen), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
